// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller, its ALU decoder
// and the datapath/ALU that consume the select codes.
//   state_e            : controller state encodings (also shown on STATE)
//   OP_* / FN_*        : opcode and R-type funct values
//   ALU_*              : ALU_OP codes understood by the ALU
//   SRCB_* / PCSRC_*   : ALU operand-B and PC source mux selects
//   op_zero_ext()      : 1 for the logical immediates that zero-extend imm16
package mips_multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_RTEXE  = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ITEXE  = 4'd9,
      ST_JUMP   = 4'd10
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_LUI  = 4'd5;

   localparam logic [1:0] SRCB_RT      = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // andi/ori treat imm16 as unsigned; everything else sign-extends.
   function automatic logic op_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU control decoder for the multi-cycle MIPS controller.
//   state    in   current controller state
//   op       in   instruction opcode (IR[31:26])
//   funct    in   R-type function field (IR[5:0])
//   alu_op   out  ALU operation code
//   ext_s    out  1 = sign-extend imm16, 0 = zero-extend
//   funct_ok out  funct is one of the supported R-type operations
module mips_alu_dec
   import mips_multicycle_ctrl_pkg::*;
(
   input  state_e      state,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   output logic [3:0]  alu_op,
   output logic        ext_s,
   output logic        funct_ok
);

   logic [3:0] fn_alu_s;
   logic [3:0] imm_alu_s;

   // R-type funct to ALU operation, flagging unsupported codes
   always_comb begin
      fn_alu_s = ALU_ADD;
      funct_ok = 1'b1;
      case (funct)
         FN_ADD:  fn_alu_s = ALU_ADD;
         FN_SUB:  fn_alu_s = ALU_SUB;
         FN_AND:  fn_alu_s = ALU_AND;
         FN_OR:   fn_alu_s = ALU_OR;
         FN_SLT:  fn_alu_s = ALU_SLT;
         default: begin
            fn_alu_s = ALU_ADD;
            funct_ok = 1'b0;
         end
      endcase
   end

   // I-type opcode to ALU operation (addi and anything else add)
   always_comb begin
      imm_alu_s = ALU_ADD;
      case (op)
         OP_ANDI: imm_alu_s = ALU_AND;
         OP_ORI:  imm_alu_s = ALU_OR;
         OP_LUI:  imm_alu_s = ALU_LUI;
         default: imm_alu_s = ALU_ADD;
      endcase
   end

   // Per-state ALU op and extender select
   always_comb begin
      alu_op = ALU_ADD;
      ext_s  = 1'b1;
      case (state)
         ST_RTEXE:  alu_op = fn_alu_s;
         ST_BRANCH: alu_op = ALU_SUB;
         ST_ITEXE: begin
            alu_op = imm_alu_s;
            ext_s  = ~op_zero_ext(op);
         end
         // OP is still valid here, so the ITEXE extender choice is simply
         // re-derived rather than stored.
         ST_ALUWB:  ext_s = ~op_zero_ext(op);
         default: begin
            alu_op = ALU_ADD;
            ext_s  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback for R-type, lw, sw, beq, addi, andi, ori, lui and j.
//   CLK, RST                : clock, synchronous active-high reset
//   OP, FUNCT, ZERO         : opcode, funct, ALU zero flag (used in BRANCH)
//   PC_WE, IR_WE            : PC / instruction register write enables
//   MEM_RD, MEM_WR, I_OR_D  : memory strobes and address select
//   REG_WE, REG_DST, MEM_TO_REG : register file write controls
//   EXT_S                   : imm16 extender sign select
//   ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SRC : datapath selects
//   ILLEGAL                 : one-cycle pulse on unsupported OP/FUNCT
//   STATE                   : current state encoding (debug)
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4,
   parameter int STATE_W = 4
)(
   input  logic               CLK,
   input  logic               RST,
   input  logic [5:0]         OP,
   input  logic [5:0]         FUNCT,
   input  logic               ZERO,
   output logic               PC_WE,
   output logic               IR_WE,
   output logic               MEM_RD,
   output logic               MEM_WR,
   output logic               I_OR_D,
   output logic               REG_WE,
   output logic               REG_DST,
   output logic               MEM_TO_REG,
   output logic               EXT_S,
   output logic               ALU_SRC_A,
   output logic [1:0]         ALU_SRC_B,
   output logic [ALUOP_W-1:0] ALU_OP,
   output logic [1:0]         PC_SRC,
   output logic               ILLEGAL,
   output logic [STATE_W-1:0] STATE
);

   state_e     state_r;
   state_e     state_next_s;
   logic [3:0] dec_alu_op_s;
   logic       dec_ext_s;
   logic       funct_ok_s;
   logic [3:0] alu_op_s;

   mips_alu_dec u_alu_dec (
      .state    (state_r),
      .op       (OP),
      .funct    (FUNCT),
      .alu_op   (dec_alu_op_s),
      .ext_s    (dec_ext_s),
      .funct_ok (funct_ok_s)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and Moore output decode; while RST is high everything is
   // forced to its idle value so a reset mid-instruction cannot write.
   always_comb begin
      state_next_s = ST_FETCH;
      PC_WE        = 1'b0;
      IR_WE        = 1'b0;
      MEM_RD       = 1'b0;
      MEM_WR       = 1'b0;
      I_OR_D       = 1'b0;
      REG_WE       = 1'b0;
      REG_DST      = 1'b0;
      MEM_TO_REG   = 1'b0;
      EXT_S        = 1'b1;
      ALU_SRC_A    = 1'b0;
      ALU_SRC_B    = SRCB_RT;
      alu_op_s     = ALU_ADD;
      PC_SRC       = PCSRC_ALU;
      ILLEGAL      = 1'b0;
      if (!RST) begin
         alu_op_s = dec_alu_op_s;
         EXT_S    = dec_ext_s;
         case (state_r)
            ST_FETCH: begin
               MEM_RD       = 1'b1;
               IR_WE        = 1'b1;
               PC_WE        = 1'b1;
               ALU_SRC_B    = SRCB_FOUR;
               state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
               // ALU precomputes PC + (imm<<2) for a possible branch
               ALU_SRC_B = SRCB_IMM_SH2;
               case (OP)
                  OP_RTYPE:                         state_next_s = ST_RTEXE;
                  OP_LW, OP_SW:                     state_next_s = ST_MEMADR;
                  OP_BEQ:                           state_next_s = ST_BRANCH;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next_s = ST_ITEXE;
                  OP_J:                             state_next_s = ST_JUMP;
                  default: begin
                     state_next_s = ST_FETCH;
                     ILLEGAL      = 1'b1;
                  end
               endcase
            end
            ST_MEMADR: begin
               ALU_SRC_A = 1'b1;
               ALU_SRC_B = SRCB_IMM;
               if (OP == OP_SW) begin
                  state_next_s = ST_MEMWR;
               end else begin
                  state_next_s = ST_MEMRD;
               end
            end
            ST_MEMRD: begin
               MEM_RD       = 1'b1;
               I_OR_D       = 1'b1;
               state_next_s = ST_MEMWB;
            end
            ST_MEMWB: begin
               REG_WE       = 1'b1;
               MEM_TO_REG   = 1'b1;
               state_next_s = ST_FETCH;
            end
            ST_MEMWR: begin
               MEM_WR       = 1'b1;
               I_OR_D       = 1'b1;
               state_next_s = ST_FETCH;
            end
            ST_RTEXE: begin
               ALU_SRC_A = 1'b1;
               if (funct_ok_s) begin
                  state_next_s = ST_ALUWB;
               end else begin
                  state_next_s = ST_FETCH;
                  ILLEGAL      = 1'b1;
               end
            end
            ST_ALUWB: begin
               REG_WE       = 1'b1;
               REG_DST      = (OP == OP_RTYPE);
               state_next_s = ST_FETCH;
            end
            ST_BRANCH: begin
               ALU_SRC_A    = 1'b1;
               PC_SRC       = PCSRC_ALUOUT;
               PC_WE        = ZERO;
               state_next_s = ST_FETCH;
            end
            ST_ITEXE: begin
               ALU_SRC_A    = 1'b1;
               ALU_SRC_B    = SRCB_IMM;
               state_next_s = ST_ALUWB;
            end
            ST_JUMP: begin
               PC_WE        = 1'b1;
               PC_SRC       = PCSRC_JUMP;
               state_next_s = ST_FETCH;
            end
            default: begin
               // encodings 11-15 only arise from an upset; recover
               state_next_s = ST_FETCH;
               ILLEGAL      = 1'b1;
            end
         endcase
      end else begin
         state_next_s = ST_FETCH;
      end
   end

   assign ALU_OP = ALUOP_W'(alu_op_s);
   assign STATE  = STATE_W'(state_r);

endmodule
